// File: rtl/mem_pkg.sv
// Shared encodings and lane-steering helpers for the MEM-stage load/store engine.
// Pure declarations; no state.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Reserved size 2'b11 falls through to the word case.
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: be_gen = 4'b0001 << a;
            SZ_HALF: be_gen = 4'b0011 << {a[1], 1'b0};
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_gen(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_BYTE: wdata_gen = {4{wd[7:0]}};
            SZ_HALF: wdata_gen = {2{wd[15:0]}};
            default: wdata_gen = wd;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the byte/half lane of a read word and sign- or zero-extends it to 32 bits.
// Latency: combinational. Backpressure: none.
// Flow control: pure function of its inputs.
module load_extender
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic [1:0]  a,
    input  logic        is_unsigned,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (a)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = a[1] ? rdata[31:16] : rdata[15:0];

        ext = rdata;
        case (size)
            SZ_BYTE: ext = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: ext = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: steers store lanes, runs a req/ack access, extends loads.
// Latency: non-memory ops pass through combinationally; memory ops take IDLE + N REQ cycles + one RESP cycle.
// Backpressure: stall holds the upstream pipeline until RESP; optional MISALIGN_TRAP_EN traps misaligned half/word.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    input  logic [1:0]        inMemSize,
    input  logic              inLoadUnsigned,
    input  logic [31:0]       inALUResult,
    input  logic [31:0]       inWriteData,
    input  logic [4:0]        inWriteReg,
    input  logic              inRegWrite,
    input  logic              inMemToReg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic              outValid,
    output logic              outRegWrite,
    output logic              outMemToReg,
    output logic [4:0]        outWriteReg,
    output logic [31:0]       outALUResult,
    output logic [31:0]       outReadData,
    output logic              outBusError,
    output logic              outMisalign
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                load_q, load_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [31:0]         alu_q, alu_d;
    logic [4:0]          wreg_q, wreg_d;
    logic                regwrite_q, regwrite_d;
    logic                memtoreg_q, memtoreg_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                buserr_q, buserr_d;
    logic                mis_q, mis_d;

    logic                is_mem;
    logic                mis;
    logic [31:0]         load_ext;

    load_extender u_load_extender (
        .rdata       (mem_rdata),
        .size        (size_q),
        .a           (alu_q[1:0]),
        .is_unsigned (uns_q),
        .ext         (load_ext)
    );

    assign is_mem = inValid & (inMemRead | inMemWrite);

`ifdef MISALIGN_TRAP_EN
    assign mis = ((inMemSize == SZ_HALF) & inALUResult[0]) |
                 (inMemSize[1] & (inALUResult[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Bus fields come straight from registers so they stay stable across the whole REQ phase.
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_d     = load_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        alu_d      = alu_q;
        wreg_d     = wreg_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        buserr_d   = buserr_q;
        mis_d      = mis_q;

        mem_req      = 1'b0;
        stall        = 1'b0;
        outValid     = inValid;
        outRegWrite  = inRegWrite;
        outMemToReg  = inMemToReg;
        outWriteReg  = inWriteReg;
        outALUResult = inALUResult;
        outReadData  = 32'h0;
        outBusError  = 1'b0;
        outMisalign  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_mem) begin
                    stall      = 1'b1;
                    outValid   = 1'b0;
                    load_d     = inMemRead;
                    we_d       = ~inMemRead;
                    size_d     = inMemSize;
                    uns_d      = inLoadUnsigned;
                    alu_d      = inALUResult;
                    wreg_d     = inWriteReg;
                    regwrite_d = inRegWrite & ~mis;
                    memtoreg_d = inMemToReg;
                    addr_d     = inALUResult[ADDR_W+1:2];
                    be_d       = be_gen(inMemSize, inALUResult[1:0]);
                    wdata_d    = wdata_gen(inMemSize, inWriteData);
                    rdata_d    = 32'h0;
                    buserr_d   = 1'b0;
                    mis_d      = mis;
                    cnt_d      = 8'h0;
                    state_d    = mis ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req      = 1'b1;
                stall        = 1'b1;
                outValid     = 1'b0;
                outRegWrite  = regwrite_q;
                outMemToReg  = memtoreg_q;
                outWriteReg  = wreg_q;
                outALUResult = alu_q;
                if (mem_ack) begin
                    rdata_d = load_q ? load_ext : 32'h0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        buserr_d   = 1'b1;
                        rdata_d    = 32'h0;
                        regwrite_d = 1'b0;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                outValid     = 1'b1;
                outRegWrite  = regwrite_q;
                outMemToReg  = memtoreg_q;
                outWriteReg  = wreg_q;
                outALUResult = alu_q;
                outReadData  = rdata_q;
                outBusError  = buserr_q;
                outMisalign  = mis_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'h0;
            load_q     <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            alu_q      <= 32'h0;
            wreg_q     <= 5'h0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            buserr_q   <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            load_q     <= load_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            alu_q      <= alu_d;
            wreg_q     <= wreg_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            buserr_q   <= buserr_d;
            mis_q      <= mis_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT=4; expectations follow MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int ADDR_W  = 30;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              inValid, inMemRead, inMemWrite, inLoadUnsigned, inRegWrite, inMemToReg;
    logic [1:0]        inMemSize;
    logic [31:0]       inALUResult, inWriteData;
    logic [4:0]        inWriteReg;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              stall, outValid, outRegWrite, outMemToReg, outBusError, outMisalign;
    logic [4:0]        outWriteReg;
    logic [31:0]       outALUResult, outReadData;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inMemSize(inMemSize), .inLoadUnsigned(inLoadUnsigned),
        .inALUResult(inALUResult), .inWriteData(inWriteData),
        .inWriteReg(inWriteReg), .inRegWrite(inRegWrite), .inMemToReg(inMemToReg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .outValid(outValid), .outRegWrite(outRegWrite),
        .outMemToReg(outMemToReg), .outWriteReg(outWriteReg),
        .outALUResult(outALUResult), .outReadData(outReadData),
        .outBusError(outBusError), .outMisalign(outMisalign)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        inValid = 1'b1; inMemRead = rd; inMemWrite = wr; inMemSize = sz;
        inLoadUnsigned = uns; inALUResult = a; inWriteData = wd;
        inWriteReg = 5'd9; inRegWrite = rd; inMemToReg = rd;
        #1;
    endtask

    task automatic clear_op;
        inValid = 1'b0; inMemRead = 1'b0; inMemWrite = 1'b0;
        tick();
    endtask

    // Steps the access until the RESP cycle; ack_after=0 means never acknowledge.
    task automatic run_op(input int ack_after, input logic [31:0] rdata,
                          output int stalls, output int reqs, output logic stable,
                          output logic [31:0] addr0, output logic [3:0] be0,
                          output logic we0, output logic [31:0] wd0);
        logic done;
        done = 1'b0; stalls = 0; reqs = 0; stable = 1'b1;
        addr0 = 32'h0; be0 = 4'h0; we0 = 1'b0; wd0 = 32'h0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (stall) stalls++;
            if (mem_req) begin
                if (reqs == 0) begin
                    addr0 = 32'(mem_addr); be0 = mem_be; we0 = mem_we; wd0 = mem_wdata;
                end else if (32'(mem_addr) != addr0 || mem_be != be0 || mem_we != we0 || mem_wdata != wd0) begin
                    stable = 1'b0;
                end
                reqs++;
                if (reqs == ack_after) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end
            end
            tick();
            mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
            if (outValid) done = 1'b1;
        end
        chk("resp_reached", 32'(done), 32'd1);
    endtask

    int          st, rq;
    logic        stb, we;
    logic [31:0] ad, wd;
    logic [3:0]  be;

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        inValid = 1'b0; inMemRead = 1'b0; inMemWrite = 1'b0; inMemSize = 2'b00;
        inLoadUnsigned = 1'b0; inALUResult = 32'h0; inWriteData = 32'h0;
        inWriteReg = 5'd0; inRegWrite = 1'b0; inMemToReg = 1'b0;
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_req",    32'(mem_req),     32'd0);
        chk("rst_stall",  32'(stall),       32'd0);
        chk("rst_valid",  32'(outValid),    32'd0);
        chk("rst_buserr", 32'(outBusError), 32'd0);
        chk("rst_mis",    32'(outMisalign), 32'd0);

        // lw @0x100, ack on the 3rd REQ cycle
        set_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
        chk("t1_idle_valid", 32'(outValid), 32'd0);
        run_op(3, 32'hDEADBEEF, st, rq, stb, ad, be, we, wd);
        chk("t1_stalls", 32'(st), 32'd4);
        chk("t1_addr",   ad, 32'h40);
        chk("t1_be",     32'(be), 32'hF);
        chk("t1_we",     32'(we), 32'd0);
        chk("t1_rdata",  outReadData, 32'hDEADBEEF);
        chk("t1_stall_resp", 32'(stall), 32'd0);
        chk("t1_regwr",  32'(outRegWrite), 32'd1);
        chk("t1_wreg",   32'(outWriteReg), 32'd9);
        chk("t1_alu",    outALUResult, 32'h100);
        chk("t1_req_resp", 32'(mem_req), 32'd0);
        clear_op();
        chk("t1_idle_after", 32'(outValid), 32'd0);

        // byte and halfword loads
        set_op(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0);
        run_op(1, 32'h80FF_0000, st, rq, stb, ad, be, we, wd);
        chk("t2_lb_be", 32'(be), 32'h8);
        chk("t2_lb",    outReadData, 32'hFFFFFF80);
        clear_op();
        set_op(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0);
        run_op(1, 32'h80FF_0000, st, rq, stb, ad, be, we, wd);
        chk("t2_lbu", outReadData, 32'h00000080);
        clear_op();
        set_op(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h0);
        run_op(2, 32'h0000_7F00, st, rq, stb, ad, be, we, wd);
        chk("t2_lb_pos", outReadData, 32'h0000007F);
        clear_op();
        set_op(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0);
        run_op(1, 32'h80FF_0000, st, rq, stb, ad, be, we, wd);
        chk("t2_lh_be", 32'(be), 32'hC);
        chk("t2_lh",    outReadData, 32'hFFFF80FF);
        clear_op();
        set_op(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0);
        run_op(1, 32'h1234_F00D, st, rq, stb, ad, be, we, wd);
        chk("t2_lhu_be", 32'(be), 32'h3);
        chk("t2_lhu",    outReadData, 32'h0000F00D);
        clear_op();

        // stores
        set_op(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h102, 32'h1234ABCD);
        run_op(3, 32'hFFFF_FFFF, st, rq, stb, ad, be, we, wd);
        chk("t3_sh_be",     32'(be), 32'hC);
        chk("t3_sh_wdata",  wd, 32'hABCDABCD);
        chk("t3_sh_we",     32'(we), 32'd1);
        chk("t3_sh_stable", 32'(stb), 32'd1);
        chk("t3_sh_reqs",   32'(rq), 32'd3);
        chk("t3_sh_rdata",  outReadData, 32'h0);
        clear_op();
        set_op(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h000000EF);
        run_op(1, 32'h0, st, rq, stb, ad, be, we, wd);
        chk("t3_sb_be",    32'(be), 32'h2);
        chk("t3_sb_wdata", wd, 32'hEFEFEFEF);
        clear_op();
        set_op(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h104, 32'hCAFEF00D);
        run_op(1, 32'h0, st, rq, stb, ad, be, we, wd);
        chk("t3_sw_addr",  ad, 32'h41);
        chk("t3_sw_wdata", wd, 32'hCAFEF00D);
        clear_op();

        // read+write together is a load; reserved size is a word
        set_op(1'b1, 1'b1, 2'b11, 1'b0, 32'h208, 32'h0);
        run_op(1, 32'h0BAD_CAFE, st, rq, stb, ad, be, we, wd);
        chk("t3_rw_we",   32'(we), 32'd0);
        chk("t3_rsv_be",  32'(be), 32'hF);
        chk("t3_rsv_rd",  outReadData, 32'h0BADCAFE);
        clear_op();

        // timeout
        set_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0);
        run_op(0, 32'h0, st, rq, stb, ad, be, we, wd);
        chk("t4_reqs",   32'(rq), 32'd4);
        chk("t4_stalls", 32'(st), 32'd5);
        chk("t4_buserr", 32'(outBusError), 32'd1);
        chk("t4_regwr",  32'(outRegWrite), 32'd0);
        chk("t4_rdata",  outReadData, 32'h0);
        clear_op();
        chk("t4_buserr_idle", 32'(outBusError), 32'd0);

        // reset during REQ, late ack ignored
        set_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0);
        tick();
        chk("t5_req", 32'(mem_req), 32'd1);
        rst = 1'b1; inValid = 1'b0; inMemRead = 1'b0;
        tick();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12121212; #1;
        chk("t5_req_after", 32'(mem_req), 32'd0);
        chk("t5_valid0",    32'(outValid), 32'd0);
        tick();
        mem_ack = 1'b0; #1;
        chk("t5_valid1", 32'(outValid), 32'd0);
        chk("t5_req1",   32'(mem_req), 32'd0);
        inValid = 1'b1; inMemRead = 1'b0; inMemWrite = 1'b0; inALUResult = 32'h12345678;
        inWriteReg = 5'd7; inRegWrite = 1'b1; #1;
        chk("t5_alu_valid", 32'(outValid), 32'd1);
        chk("t5_alu_stall", 32'(stall), 32'd0);
        chk("t5_alu_res",   outALUResult, 32'h12345678);
        chk("t5_alu_wreg",  32'(outWriteReg), 32'd7);
        chk("t5_alu_rdata", outReadData, 32'h0);
        tick();
        chk("t5_alu_req", 32'(mem_req), 32'd0);

        // misaligned word
        set_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0);
        run_op(1, 32'h11223344, st, rq, stb, ad, be, we, wd);
`ifdef MISALIGN_TRAP_EN
        chk("t6_reqs",   32'(rq), 32'd0);
        chk("t6_stalls", 32'(st), 32'd1);
        chk("t6_mis",    32'(outMisalign), 32'd1);
        chk("t6_regwr",  32'(outRegWrite), 32'd0);
        chk("t6_rdata",  outReadData, 32'h0);
`else
        chk("t6_addr",  ad, 32'h40);
        chk("t6_be",    32'(be), 32'hF);
        chk("t6_mis",   32'(outMisalign), 32'd0);
        chk("t6_rdata", outReadData, 32'h11223344);
`endif
        clear_op();
        chk("t6_mis_idle", 32'(outMisalign), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
